// File: rtl/arm_exec_unit.sv
// rtl/arm_exec_unit.sv - single-cycle ARM data-processing execute stage with NZCV flags and sticky halt
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   valid_in   inst and operand values are present this cycle
//   inst       ARM instruction word
//   rn_val     value of Rn (inst[19:16])
//   rm_val     value of Rm (inst[3:0])
//   rs_val     value of Rs (inst[11:8])
//   result     registered ALU result (updated every cycle)
//   rd_idx     registered destination index inst[15:12]
//   rd_we      registered write enable for rd_idx
//   flags      current NZCV, [3]=N [2]=Z [1]=C [0]=V
//   valid_out  registered copy of valid_in
//   halted     sticky, set by a valid HALT_INST
module arm_exec_unit #(
   parameter logic [31:0] HALT_INST = 32'hE3A000BB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] inst,
   input  logic [31:0] rn_val,
   input  logic [31:0] rm_val,
   input  logic [31:0] rs_val,
   output logic [31:0] result,
   output logic [3:0]  rd_idx,
   output logic        rd_we,
   output logic [3:0]  flags,
   output logic        valid_out,
   output logic        halted
);

   logic flag_n, flag_z, flag_c, flag_v;
   assign flag_n = flags[3];
   assign flag_z = flags[2];
   assign flag_c = flags[1];
   assign flag_v = flags[0];

   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
      // r == 0 makes the left term a shift by 32, which is zero, so v passes through
      return (v >> r) | (v << (6'd32 - {1'b0, r}));
   endfunction

   // ---------------- condition ----------------
   logic cond_pass;

   always_comb begin
      cond_pass = 1'b0;
      case (inst[31:28])
         4'h0:    cond_pass = flag_z;
         4'h1:    cond_pass = !flag_z;
         4'h2:    cond_pass = flag_c;
         4'h3:    cond_pass = !flag_c;
         4'h4:    cond_pass = flag_n;
         4'h5:    cond_pass = !flag_n;
         4'h6:    cond_pass = flag_v;
         4'h7:    cond_pass = !flag_v;
         4'h8:    cond_pass = flag_c && !flag_z;
         4'h9:    cond_pass = !flag_c || flag_z;
         4'hA:    cond_pass = (flag_n == flag_v);
         4'hB:    cond_pass = (flag_n != flag_v);
         4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
         4'hD:    cond_pass = flag_z || (flag_n != flag_v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // ---------------- barrel shifter ----------------
   logic [1:0]  sh_type;
   logic [4:0]  imm_amt;
   logic [7:0]  amt8;
   logic [32:0] t33;
   logic [31:0] shift_out;
   logic        shift_c;

   assign sh_type = inst[6:5];
   assign imm_amt = inst[11:7];

   always_comb begin
      shift_out = rm_val;
      shift_c   = flag_c;
      amt8      = 8'd0;
      t33       = 33'd0;
      if (inst[25]) begin
         shift_out = ror32({24'd0, inst[7:0]}, {inst[11:8], 1'b0});
         shift_c   = (inst[11:8] == 4'd0) ? flag_c : shift_out[31];
      end else if (!inst[4] && imm_amt == 5'd0 && sh_type == 2'b11) begin
         // ROR #0 is RRX
         shift_out = {flag_c, rm_val[31:1]};
         shift_c   = rm_val[0];
      end else begin
         if (inst[4])
            amt8 = rs_val[7:0];
         else if (imm_amt == 5'd0 && sh_type != 2'b00)
            amt8 = 8'd32;            // LSR #0 / ASR #0 encode a shift by 32
         else
            amt8 = {3'd0, imm_amt};
         if (amt8 != 8'd0) begin
            // 33-bit shifts carry the last bit shifted out in the extra position
            case (sh_type)
               2'b00: begin
                  if (amt8 <= 8'd32) begin
                     t33       = {1'b0, rm_val} << amt8;
                     shift_out = t33[31:0];
                     shift_c   = t33[32];
                  end else begin
                     shift_out = 32'd0;
                     shift_c   = 1'b0;
                  end
               end
               2'b01: begin
                  if (amt8 <= 8'd32) begin
                     t33       = {rm_val, 1'b0} >> amt8;
                     shift_out = t33[32:1];
                     shift_c   = t33[0];
                  end else begin
                     shift_out = 32'd0;
                     shift_c   = 1'b0;
                  end
               end
               2'b10: begin
                  t33       = $signed({rm_val, 1'b0}) >>> ((amt8 >= 8'd32) ? 8'd32 : amt8);
                  shift_out = t33[32:1];
                  shift_c   = t33[0];
               end
               default: begin
                  if (amt8[4:0] == 5'd0) begin
                     shift_out = rm_val;
                     shift_c   = rm_val[31];
                  end else begin
                     shift_out = ror32(rm_val, amt8[4:0]);
                     shift_c   = shift_out[31];
                  end
               end
            endcase
         end
      end
   end

   // ---------------- ALU ----------------
   logic [3:0]  opcode;
   logic [31:0] add_a, add_b;
   logic        add_cin;
   logic [32:0] sum33;
   logic        add_v;
   logic [31:0] alu_res;
   logic        is_arith, is_test, is_dp;

   assign opcode   = inst[24:21];
   assign is_arith = (opcode[3:1] == 3'b001) || (opcode[3:2] == 2'b01) || (opcode[3:1] == 3'b101);
   assign is_test  = (opcode[3:2] == 2'b10);
   // bit25=0 with bit7=bit4=1 is the multiply / extra load-store space
   assign is_dp    = (inst[27:26] == 2'b00) && !(!inst[25] && inst[7] && inst[4]);

   always_comb begin
      add_a   = rn_val;
      add_b   = shift_out;
      add_cin = 1'b0;
      case (opcode)
         4'h2, 4'hA: begin add_b = ~shift_out; add_cin = 1'b1; end
         4'h3:       begin add_a = shift_out; add_b = ~rn_val; add_cin = 1'b1; end
         4'h5:       begin add_cin = flag_c; end
         4'h6:       begin add_b = ~shift_out; add_cin = flag_c; end
         4'h7:       begin add_a = shift_out; add_b = ~rn_val; add_cin = flag_c; end
         default:    begin add_cin = 1'b0; end
      endcase
   end

   assign sum33 = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
   assign add_v = (add_a[31] == add_b[31]) && (sum33[31] != add_a[31]);

   always_comb begin
      alu_res = 32'd0;
      case (opcode)
         4'h0, 4'h8: alu_res = rn_val & shift_out;
         4'h1, 4'h9: alu_res = rn_val ^ shift_out;
         4'hC:       alu_res = rn_val | shift_out;
         4'hD:       alu_res = shift_out;
         4'hE:       alu_res = rn_val & ~shift_out;
         4'hF:       alu_res = ~shift_out;
         default:    alu_res = sum33[31:0];
      endcase
   end

   // ---------------- commit ----------------
   logic       exec_ok;
   logic       flag_we;
   logic [3:0] flags_nxt;

   assign exec_ok   = valid_in && cond_pass && is_dp;
   assign flag_we   = exec_ok && (inst[20] || is_test);
   assign flags_nxt = {alu_res[31],
                       (alu_res == 32'd0),
                       is_arith ? sum33[32] : shift_c,
                       is_arith ? add_v : flag_v};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result    <= 32'd0;
         rd_idx    <= 4'd0;
         rd_we     <= 1'b0;
         flags     <= 4'd0;
         valid_out <= 1'b0;
         halted    <= 1'b0;
      end else begin
         result    <= alu_res;
         rd_idx    <= inst[15:12];
         rd_we     <= exec_ok && !is_test;
         valid_out <= valid_in;
         if (flag_we)
            flags <= flags_nxt;
         if (valid_in && inst == HALT_INST)
            halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arm_exec_unit.sv
// tb/tb_arm_exec_unit.sv - directed self-checking bench for arm_exec_unit
module tb_arm_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] inst, rn_val, rm_val, rs_val;
   logic [31:0] result;
   logic [3:0]  rd_idx;
   logic        rd_we;
   logic [3:0]  flags;
   logic        valid_out;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;

   arm_exec_unit #(.HALT_INST(32'hE3A000BB)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .inst      (inst),
      .rn_val    (rn_val),
      .rm_val    (rm_val),
      .rs_val    (rs_val),
      .result    (result),
      .rd_idx    (rd_idx),
      .rd_we     (rd_we),
      .flags     (flags),
      .valid_out (valid_out),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [31:0] i, input logic [31:0] n, input logic [31:0] m,
                       input logic [31:0] s, input logic v);
      @(negedge clk);
      inst = i; rn_val = n; rm_val = m; rs_val = s; valid_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_result"}, result, 32'h0);
      check({tag, "_rd_idx"}, {28'd0, rd_idx}, 32'h0);
      check({tag, "_rd_we"}, {31'd0, rd_we}, 32'h0);
      check({tag, "_flags"}, {28'd0, flags}, 32'h0);
      check({tag, "_valid_out"}, {31'd0, valid_out}, 32'h0);
      check({tag, "_halted"}, {31'd0, halted}, 32'h0);
   endtask

   initial begin
      rst = 1'b0; valid_in = 1'b1; inst = 32'hE3A000BB;
      rn_val = 32'd0; rm_val = 32'd0; rs_val = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");

      // first instruction sampled on the first rising edge after release
      rst = 1'b1;
      inst = 32'hE3A014FF; rn_val = 32'd0; rm_val = 32'd0; rs_val = 32'd0; valid_in = 1'b1;
      @(posedge clk); #1;
      check("mov_imm_result", result, 32'hFF000000);
      check("mov_imm_rd_idx", {28'd0, rd_idx}, 32'h1);
      check("mov_imm_rd_we", {31'd0, rd_we}, 32'h1);
      check("mov_imm_flags", {28'd0, flags}, 32'h0);
      check("mov_imm_valid_out", {31'd0, valid_out}, 32'h1);
      check("mov_imm_halted", {31'd0, halted}, 32'h0);

      step(32'hE2900001, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1);
      check("adds_ovf_result", result, 32'h80000000);
      check("adds_ovf_flags", {28'd0, flags}, 32'h9);
      check("adds_ovf_rd_idx", {28'd0, rd_idx}, 32'h0);

      step(32'hE1520003, 32'h5, 32'h5, 32'h0, 1'b1);
      check("cmp_rd_we", {31'd0, rd_we}, 32'h0);
      check("cmp_flags", {28'd0, flags}, 32'h6);

      step(32'h13A00001, 32'h0, 32'h0, 32'h0, 1'b1);
      check("movne_fail_rd_we", {31'd0, rd_we}, 32'h0);
      check("movne_fail_result", result, 32'h1);

      step(32'h03A00001, 32'h0, 32'h0, 32'h0, 1'b1);
      check("moveq_result", result, 32'h1);
      check("moveq_rd_we", {31'd0, rd_we}, 32'h1);
      check("moveq_flags", {28'd0, flags}, 32'h6);

      // asynchronous reset between clock edges
      #2 rst = 1'b0;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      valid_in = 1'b0;
      rst = 1'b1;

      step(32'hE1B00021, 32'h0, 32'h80000000, 32'h0, 1'b1);
      check("lsr32_result", result, 32'h0);
      check("lsr32_flags", {28'd0, flags}, 32'h6);

      step(32'hE1B00211, 32'h0, 32'h1, 32'd33, 1'b1);
      check("lsl33_result", result, 32'h0);
      check("lsl33_flags", {28'd0, flags}, 32'h4);

      step(32'hE1B00211, 32'h0, 32'h1, 32'd32, 1'b1);
      check("lsl32_result", result, 32'h0);
      check("lsl32_flags", {28'd0, flags}, 32'h6);

      step(32'hE1B00211, 32'h0, 32'h1, 32'd0, 1'b1);
      check("lsl0_result", result, 32'h1);
      check("lsl0_flags", {28'd0, flags}, 32'h2);

      step(32'h02900001, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1);
      check("addeq_fail_result", result, 32'h80000000);
      check("addeq_fail_rd_we", {31'd0, rd_we}, 32'h0);
      check("addeq_fail_flags", {28'd0, flags}, 32'h2);

      step(32'hE2900001, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b0);
      check("novalid_result", result, 32'h80000000);
      check("novalid_rd_we", {31'd0, rd_we}, 32'h0);
      check("novalid_valid_out", {31'd0, valid_out}, 32'h0);
      check("novalid_flags", {28'd0, flags}, 32'h2);

      step(32'hE2500001, 32'h0, 32'h0, 32'h0, 1'b1);
      check("subs_borrow_result", result, 32'hFFFFFFFF);
      check("subs_borrow_flags", {28'd0, flags}, 32'h8);

      step(32'hE5910000, 32'h0, 32'h0, 32'h0, 1'b1);
      check("ldr_rd_we", {31'd0, rd_we}, 32'h0);
      check("ldr_flags", {28'd0, flags}, 32'h8);

      step(32'hE0100091, 32'h0, 32'h0, 32'h0, 1'b1);
      check("mul_rd_we", {31'd0, rd_we}, 32'h0);
      check("mul_flags", {28'd0, flags}, 32'h8);

      step(32'hE1B00061, 32'h0, 32'h3, 32'h0, 1'b1);
      check("rrx_result", result, 32'h1);
      check("rrx_flags", {28'd0, flags}, 32'h2);

      step(32'hE0B00001, 32'h1, 32'h2, 32'h0, 1'b1);
      check("adc_result", result, 32'h4);
      check("adc_flags", {28'd0, flags}, 32'h0);

      step(32'hE3A000BB, 32'h0, 32'h0, 32'h0, 1'b1);
      check("halt_result", result, 32'hBB);
      check("halt_halted", {31'd0, halted}, 32'h1);

      step(32'hE3A014FF, 32'h0, 32'h0, 32'h0, 1'b1);
      check("post_halt_result", result, 32'hFF000000);
      check("post_halt_halted", {31'd0, halted}, 32'h1);
      check("post_halt_rd_we", {31'd0, rd_we}, 32'h1);

      #2 rst = 1'b0;
      #1;
      check("halt_clear", {31'd0, halted}, 32'h0);
      check("halt_clear_result", result, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
